// File: rtl/result_uart_pkg.sv
// Shared types and helpers for the result UART dump path.
// Covers the address sequencer states, the byte serialiser states and the baud divider.
package result_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_LATCH,
        ST_SEND,
        ST_NEXT
    } seq_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Clocks per serial bit; a divider below 2 cannot form a usable bit period.
    function automatic int calc_bit_ticks(input int clk_freq, input int baud);
        int ticks;
        ticks = clk_freq / baud;
        return (ticks < 2) ? 2 : ticks;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Serialises one byte as an 8N1 frame, LSB first.
// The frame_end pulse marks the last clock of the stop bit.
//
// state    | meaning
// TX_IDLE  | line high, in_ready=1, waiting for in_valid
// TX_START | start bit (low) for BIT_TICKS clocks
// TX_DATA  | data bit r_shift[0] for BIT_TICKS clocks, DATA_BITS times
// TX_STOP  | stop bit (high) for BIT_TICKS clocks
module uart_tx_byte
    import result_uart_pkg::*;
#(
    parameter int BIT_TICKS = 2,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 frame_end
);

    localparam int CNT_W = $clog2(BIT_TICKS);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    tx_state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 w_frame_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // tx is registered, so each branch computes the level for the bit that starts on this edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_frame_end = 1'b0;
        case (r_state)
            TX_IDLE: begin
                w_tx_nxt = 1'b1;
                if (in_valid) begin
                    w_shift_nxt = in_data;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = TX_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
                    if (r_idx == IDX_LAST) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = TX_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                        w_tx_nxt  = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                w_tx_nxt = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_frame_end = 1'b1;
                    w_state_nxt = TX_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign in_ready  = (r_state == TX_IDLE);
    assign tx        = r_tx;
    assign frame_end = w_frame_end;

endmodule

// File: rtl/result_uart_tx.sv
// Walks result RAM addresses 0..NUM_SAMPLES-1 and streams each byte over UART 8N1.
// Owns the RAM read port while busy; serialisation is delegated to uart_tx_byte.
//
// state    | meaning
// ST_IDLE  | waiting for start; done holds the last completion
// ST_FETCH | ram_rdaddr stable, RAM read in progress
// ST_WAIT  | covers the one-clock RAM read latency
// ST_LATCH | ram_q valid, handed to the serialiser
// ST_SEND  | frame in flight on tx
// ST_NEXT  | finish the dump or advance the address
module result_uart_tx
    import result_uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 115200,
    parameter int ADDR_BITS   = 8,
    parameter int DATA_BITS   = 8,
    parameter int NUM_SAMPLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [ADDR_BITS-1:0] ram_rdaddr,
    input  logic [DATA_BITS-1:0] ram_q,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int BIT_TICKS = calc_bit_ticks(CLK_FREQ, BAUD);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_SAMPLES - 1);

    seq_state_t           r_state, w_state_nxt;
    logic [ADDR_BITS-1:0] r_addr, w_addr_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 w_byte_valid;
    logic                 w_byte_ready;
    logic                 w_frame_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;
        w_byte_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_addr_nxt  = '0;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: w_state_nxt = ST_WAIT;
            ST_WAIT:  w_state_nxt = ST_LATCH;
            ST_LATCH: begin
                w_byte_valid = 1'b1;
                if (w_byte_ready) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_frame_end) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // Compare before incrementing so a full 2^ADDR_BITS dump never wraps.
                if (r_addr == LAST_ADDR) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_addr_nxt  = r_addr + 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    uart_tx_byte #(
        .BIT_TICKS (BIT_TICKS),
        .DATA_BITS (DATA_BITS)
    ) u_tx_byte (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_byte_valid),
        .in_data   (ram_q),
        .in_ready  (w_byte_ready),
        .tx        (tx),
        .frame_end (w_frame_end)
    );

    assign ram_rdaddr = r_addr;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
